// File: rtl/reg_scan_checker.sv
// End-of-run register checker for sccomp: runs the CPU until halt or budget,
// then scans a register window against an expected table.
module reg_scan_checker #(
  parameter int FIRST_REG   = 1,
  parameter int LAST_REG    = 10,
  parameter int SETTLE      = 1,
  parameter int RUN_CYCLES  = 200,
  parameter int STALL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] pc_in,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  input  logic        exp_we,
  input  logic [4:0]  exp_addr,
  input  logic [31:0] exp_data,
  input  logic        exp_clr,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_count,
  output logic [4:0]  first_err_reg,
  output logic [31:0] first_err_data,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE, RUN, SEL, WAIT, CMP, DONE
  } state_t;

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  state_t      state;
  logic [31:0] exp_mem [32];
  logic [31:0] valid;
  logic [31:0] run_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] wait_cnt;
  logic [31:0] last_pc;
  logic [4:0]  idx;

  logic        pc_same;
  logic        stall_hit;
  logic        run_hit;
  logic        mism;
  logic [5:0]  err_nxt;

  always_comb begin
    pc_same   = (pc_in == last_pc);
    stall_hit = pc_same && (stall_cnt == 32'(STALL_LIMIT - 2));
    run_hit   = (run_cnt == 32'(RUN_CYCLES - 1));
    mism      = valid[idx] && (reg_data != exp_mem[idx]);
    err_nxt   = err_count;
    if (mism && (err_count != 6'd63))
      err_nxt = err_count + 6'd1;
  end

  // Table contents are not reset; only the valid bits are.
  always_ff @(posedge clk) begin
    if (exp_we && !busy)
      exp_mem[exp_addr] <= exp_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      reg_sel        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      halted         <= 1'b0;
      err_count      <= '0;
      first_err_reg  <= '0;
      first_err_data <= '0;
      valid          <= '0;
      run_cnt        <= '0;
      stall_cnt      <= '0;
      wait_cnt       <= '0;
      last_pc        <= '0;
      idx            <= FIRST;
    end else begin
      // Clear applies before the write in the same cycle.
      if (!busy)
        valid <= (exp_clr ? 32'b0 : valid)
               | (exp_we ? (32'b1 << exp_addr) : 32'b0);
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count      <= '0;
            first_err_reg  <= '0;
            first_err_data <= '0;
            halted         <= 1'b0;
            pass           <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b1;
            run_cnt        <= '0;
            stall_cnt      <= '0;
            last_pc        <= pc_in;
            idx            <= FIRST;
            state          <= RUN;
          end
        end
        RUN: begin
          run_cnt <= run_cnt + 32'd1;
          if (pc_same) begin
            stall_cnt <= stall_cnt + 32'd1;
          end else begin
            stall_cnt <= '0;
            last_pc   <= pc_in;
          end
          if (stall_hit) begin
            halted <= 1'b1;
            state  <= SEL;
          end else if (run_hit) begin
            halted <= 1'b0;
            state  <= SEL;
          end
        end
        SEL: begin
          reg_sel  <= idx;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 32'(SETTLE - 1))
            state <= CMP;
          else
            wait_cnt <= wait_cnt + 32'd1;
        end
        CMP: begin
          err_count <= err_nxt;
          if (mism && (err_count == 6'd0)) begin
            first_err_reg  <= idx;
            first_err_data <= reg_data;
          end
          if (idx == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 6'd0);
            state <= DONE;
          end else begin
            idx   <= idx + 5'd1;
            state <= SEL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_scan_checker.sv
// Bench for reg_scan_checker: table vectors, corner sequences and
// randomized runs against a behavioural model of the check.
module tb_reg_scan_checker;

  localparam int FIRST = 1;
  localparam int LAST  = 10;
  localparam int S     = 1;
  localparam int RC    = 200;
  localparam int SL    = 16;
  localparam int NREG  = LAST - FIRST + 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc_in = '0;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        exp_we = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_clr = 1'b0;
  logic        busy, done, pass, halted;
  logic [5:0]  err_count;
  logic [4:0]  first_err_reg;
  logic [31:0] first_err_data;

  reg_scan_checker #(
    .FIRST_REG(FIRST), .LAST_REG(LAST), .SETTLE(S),
    .RUN_CYCLES(RC), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .pc_in(pc_in),
    .reg_sel(reg_sel), .reg_data(reg_data),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .exp_clr(exp_clr), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_reg(first_err_reg),
    .first_err_data(first_err_data), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [31:0] cpu_regs [32];
  always_comb reg_data = cpu_regs[reg_sel];

  logic [31:0] mexp [32];
  logic [31:0] mvalid;
  logic [31:0] pcs [300];
  logic [4:0]  sel_log [400];

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] vmask;
    logic [31:0] bmask;
    logic        pass;
    int          err;
    int          first;
    logic [31:0] fdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    exp_we = 1'b1; exp_addr = 5'(a); exp_data = d;
    @(posedge clk); #1;
    exp_we = 1'b0;
  endtask

  task automatic load_exp(input logic [31:0] vm, input logic [31:0] bm);
    for (int i = 0; i < 32; i++) wr(i, $urandom);
    exp_clr = 1'b1;
    @(posedge clk); #1;
    exp_clr = 1'b0;
    mvalid = '0;
    for (int i = 0; i < 32; i++)
      if (vm[i]) begin
        mexp[i] = bm[i] ? cpu_regs[i] + 32'd1 : cpu_regs[i];
        mvalid[i] = 1'b1;
        wr(i, mexp[i]);
      end
  endtask

  task automatic fill_pcs(input int mode);
    logic [31:0] v;
    int k;
    if (mode == 0) begin
      for (int i = 0; i < 300; i++) pcs[i] = (i < 16) ? 32'(4 * i) : 32'h40;
    end else if (mode == 1) begin
      for (int i = 0; i < 300; i++) pcs[i] = 32'h100 + 32'(4 * i);
    end else begin
      v = $urandom;
      k = 0;
      while (k < 300) begin
        int len;
        len = $urandom_range(1, 20);
        for (int j = 0; j < len && k < 300; j++) begin
          pcs[k] = v;
          k++;
        end
        v = v + 32'd4;
      end
    end
  endtask

  // Window compare straight from the table contents.
  task automatic predict(output int e, output int f, output logic [31:0] fd);
    e = 0; f = 0; fd = '0;
    for (int i = FIRST; i <= LAST; i++)
      if (mvalid[i] && cpu_regs[i] != mexp[i]) begin
        if (e == 0) begin f = i; fd = cpu_regs[i]; end
        if (e < 63) e++;
      end
  endtask

  // Edge index after start at which RUN ends, and whether by halt.
  task automatic exit_k(output int x, output bit h);
    int run;
    run = 1; x = RC; h = 1'b0;
    for (int k = 1; k <= RC; k++) begin
      run = (pcs[k] == pcs[k-1]) ? run + 1 : 1;
      if (run >= SL) begin x = k; h = 1'b1; break; end
    end
  endtask

  task automatic run_check(input int ign_at, input int abort_sel,
                           output int edges, output bit got,
                           output bit aborted);
    got = 1'b0; aborted = 1'b0; edges = 0;
    pc_in = pcs[0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("done_drops", 32'(done), 0);
    for (int k = 1; k < 400 && !got && !aborted; k++) begin
      pc_in = pcs[k < 300 ? k : 299];
      start = (k == ign_at);
      exp_we = (k == 5);
      exp_clr = (k == 5);
      exp_addr = 5'd2;
      exp_data = 32'hdead_beef;
      @(posedge clk); #1;
      sel_log[k] = reg_sel;
      edges = k + 1;
      if (done) got = 1'b1;
      if (abort_sel != 0 && reg_sel == 5'(abort_sel)) aborted = 1'b1;
    end
    start = 1'b0; exp_we = 1'b0; exp_clr = 1'b0;
  endtask

  task automatic check_result(input string tag);
    int e, f, edges, x;
    logic [31:0] fd;
    bit got, ab, h;
    predict(e, f, fd);
    exit_k(x, h);
    run_check(0, 0, edges, got, ab);
    chk({tag, "_timeout"}, 32'(got), 1);
    chk({tag, "_latency"}, edges, 1 + x + NREG * (S + 2));
    chk({tag, "_halted"}, 32'(halted), 32'(h));
    chk({tag, "_pass"}, 32'(pass), 32'(e == 0));
    chk({tag, "_err"}, 32'(err_count), e);
    chk({tag, "_first"}, 32'(first_err_reg), f);
    chk({tag, "_fdata"}, first_err_data, fd);
  endtask

  initial begin
    int edges, x;
    bit got, ab, h;
    #3000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    int edges, cnt;
    bit got, ab;
    vecs[0] = '{32'h7FE, 32'h000, 1'b1, 0, 0, 32'h0};
    vecs[1] = '{32'h7FE, 32'h020, 1'b0, 1, 5, 32'h6};
    vecs[2] = '{32'h7FE, 32'h108, 1'b0, 2, 3, 32'h4};
    vecs[3] = '{32'h006, 32'h7F8, 1'b1, 0, 0, 32'h0};
    vecs[4] = '{32'h7FE, 32'h400, 1'b0, 1, 10, 32'hB};
    vecs[5] = '{32'hFFF, 32'h801, 1'b1, 0, 0, 32'h0};
    vecs[6] = '{32'h7FE, 32'h7FE, 1'b0, 10, 1, 32'h2};
    for (int i = 0; i < 32; i++) cpu_regs[i] = 32'(i + 1);
    mvalid = '0;

    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_first", 32'(first_err_reg), 0);
    chk("rst_fdata", first_err_data, 0);
    chk("rst_sel", 32'(reg_sel), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Parked PC at 0x40: halt after 16 equal samples, edge 31.
    foreach (vecs[v]) begin
      load_exp(vecs[v].vmask, vecs[v].bmask);
      fill_pcs(0);
      run_check(0, 0, edges, got, ab);
      chk("tbl_timeout", 32'(got), 1);
      chk("tbl_latency", edges, 1 + 31 + NREG * (S + 2));
      chk("tbl_halted", 32'(halted), 1);
      chk("tbl_busy", 32'(busy), 0);
      chk("tbl_sel_last", 32'(reg_sel), LAST);
      chk("tbl_pass", 32'(pass), 32'(vecs[v].pass));
      chk("tbl_err", 32'(err_count), vecs[v].err);
      chk("tbl_first", 32'(first_err_reg), vecs[v].first);
      chk("tbl_fdata", first_err_data, vecs[v].fdata);
    end

    // Straight-line program: budget expiry, start during RUN ignored.
    load_exp(32'h7FE, 32'h0);
    fill_pcs(1);
    run_check(50, 0, edges, got, ab);
    chk("budget_timeout", 32'(got), 1);
    chk("budget_latency", edges, 231);
    chk("budget_halted", 32'(halted), 0);
    chk("budget_pass", 32'(pass), 1);
    for (int r = 1; r < LAST; r++) begin
      cnt = 0;
      for (int k = 1; k < edges; k++) if (sel_log[k] == 5'(r)) cnt++;
      chk("sel_hold", cnt, S + 2);
    end

    // Clear and write in the same cycle: only x3 ends valid.
    load_exp(32'h7FE, 32'h0);
    exp_clr = 1'b1; exp_we = 1'b1; exp_addr = 5'd3;
    exp_data = cpu_regs[3] + 32'd5;
    @(posedge clk); #1;
    exp_clr = 1'b0; exp_we = 1'b0;
    mvalid = 32'h8;
    mexp[3] = cpu_regs[3] + 32'd5;
    fill_pcs(0);
    check_result("clr_we");

    // Reset while x4 is settling.
    load_exp(32'h7FE, 32'h004);
    fill_pcs(0);
    run_check(0, 4, edges, got, ab);
    chk("abort_reached", 32'(ab), 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_err", 32'(err_count), 0);
    chk("mid_rst_first", 32'(first_err_reg), 0);
    chk("mid_rst_sel", 32'(reg_sel), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    mvalid = '0;
    @(posedge clk); #1;
    check_result("no_reload");
    load_exp(32'h7FE, 32'h004);
    check_result("reload");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) cpu_regs[i] = $urandom;
      load_exp($urandom, $urandom & $urandom);
      fill_pcs(2);
      check_result("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
